// File: rtl/word_serializer.sv
// word_serializer
// Parallel-to-serial transmitter. Words arrive on a valid/ready handshake into
// a one-word holding register and leave on a single-bit line as a frame:
// start bit (0), DATA_W data bits LSB first, even-parity bit, stop bit (1).
// Each bit lasts CLKS_PER_BIT clock cycles. The holding register lets the
// next word be reloaded straight out of the stop bit, with no idle gap.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   in_data    word to transmit, sampled on the accept edge
//   in_valid   producer offers in_data
//   in_ready   holding register empty (registered)
//   tx         serial line, idles high (registered)
//   busy       a frame is on the line (registered)
//   frame_done one-cycle pulse in the last cycle of the stop bit (registered)
module word_serializer #(
  parameter int DATA_W       = 22,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              in_ready_q, in_ready_d;
  logic              cyc_last_s;
  logic              reload_s;
  logic              accept_s;

  // Next-state logic: frame sequencing, holding-register load and drain.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    cyc_d       = cyc_q;
    bit_d       = bit_q;
    reload_s    = 1'b0;
    cyc_last_s  = (cyc_q == CNT_LAST);
    accept_s    = in_valid && in_ready_q;

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          reload_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cyc_last_s) begin
          state_d = S_DATA;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cyc_last_s) begin
          cyc_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = S_PARITY;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (cyc_last_s) begin
          state_d = S_STOP;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cyc_last_s) begin
          cyc_d = '0;
          // A held word starts right out of the stop bit, no idle cycle.
          if (hold_full_q) begin
            reload_s = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
        bit_d   = '0;
      end
    endcase

    if (reload_s) begin
      state_d     = S_START;
      shift_d     = hold_q;
      parity_d    = even_parity(hold_q);
      hold_full_d = 1'b0;
      bit_d       = '0;
      cyc_d       = '0;
    end else begin
      parity_d = parity_d;
    end

    // Reload needs hold_full=1, accept needs in_ready=1: never both at once.
    if (accept_s) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end else begin
      hold_d = hold_d;
    end
  end

  // Output decode from the next state so every output is a plain flop.
  always_comb begin
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_STOP) && (cyc_d == CNT_LAST);
    in_ready_d   = !hold_full_d;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      cyc_q        <= '0;
      bit_q        <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      cyc_q        <= cyc_d;
      bit_q        <= bit_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign in_ready   = in_ready_q;

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer
// Self-checking bench for word_serializer. A reference model describes the
// line as "which word is on air and how many cycles into its frame", and the
// expected tx level is looked up from the frame layout with plain arithmetic.
// Directed scenarios come first, then a randomized handshake phase.
module tb_word_serializer;

  localparam int DATA_W    = 22;
  localparam int CPB       = 4;
  localparam int FRAME_LEN = (DATA_W + 3) * CPB;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              tx;
  logic              busy;
  logic              frame_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_no   = 0;
  int fd_cnt   = 0;
  int fd_times[$];

  // Reference model state
  logic [DATA_W-1:0] m_hold;
  logic              m_hold_full = 1'b0;
  logic [DATA_W-1:0] m_cur;
  logic              m_active = 1'b0;
  int                m_pos = 0;
  logic              m_acc_flag = 1'b0;

  word_serializer #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc_no, obs, exp);
    end
  endtask

  // Level of bit index i of the frame carrying word w.
  function automatic logic frame_bit(input logic [DATA_W-1:0] w, input int i);
    if (i == 0) return 1'b0;
    if (i <= DATA_W) return w[i-1];
    if (i == DATA_W + 1) return ^w;
    return 1'b1;
  endfunction

  // Advance the model by one clock edge using the inputs present at it.
  task automatic model_edge(input logic rst_v, input logic v, input logic [DATA_W-1:0] d);
    logic acc;
    if (!rst_v) begin
      m_hold_full = 1'b0;
      m_active    = 1'b0;
      m_pos       = 0;
    end else begin
      acc = v && !m_hold_full;
      if (m_active) begin
        if (m_pos == FRAME_LEN - 1) begin
          if (m_hold_full) begin
            m_cur       = m_hold;
            m_hold_full = 1'b0;
            m_pos       = 0;
          end else begin
            m_active = 1'b0;
          end
        end else begin
          m_pos++;
        end
      end else if (m_hold_full) begin
        m_cur       = m_hold;
        m_hold_full = 1'b0;
        m_active    = 1'b1;
        m_pos       = 0;
      end
      if (acc) begin
        m_hold      = d;
        m_hold_full = 1'b1;
        m_acc_flag  = 1'b1;
      end
    end
  endtask

  // One clock: drive inputs, clock, update model, compare all outputs.
  task automatic cycle(input logic rst_v, input logic v, input logic [DATA_W-1:0] d);
    logic e_tx;
    reset    = rst_v;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    model_edge(rst_v, v, d);
    cyc_no++;
    @(negedge clk);
    e_tx = m_active ? frame_bit(m_cur, m_pos / CPB) : 1'b1;
    check("tx", 32'(tx), 32'(e_tx));
    check("busy", 32'(busy), 32'(m_active));
    check("frame_done", 32'(frame_done), 32'(m_active && (m_pos == FRAME_LEN - 1)));
    check("in_ready", 32'(in_ready), 32'(!m_hold_full));
    if (frame_done) begin
      fd_cnt++;
      fd_times.push_back(cyc_no);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0);
  endtask

  // Send one word from an empty line, let the frame drain, and check timing.
  task automatic single_word(input string tag, input logic [DATA_W-1:0] w);
    int acc_cyc;
    fd_times.delete();
    cycle(1'b1, 1'b1, w);
    acc_cyc = cyc_no;
    idle(FRAME_LEN + 4);
    check({tag, "_fd_count"}, 32'(fd_times.size()), 32'd1);
    if (fd_times.size() == 1) begin
      check({tag, "_fd_cycle"}, 32'(fd_times[0] - acc_cyc), 32'(FRAME_LEN));
    end else begin
      check({tag, "_fd_cycle"}, 32'hFFFF_FFFF, 32'(FRAME_LEN));
    end
  endtask

  initial begin
    int n;
    logic [DATA_W-1:0] d;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset held with a word offered: nothing may be accepted.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 22'h15A5A5);
    check("reset_no_accept", 32'(in_ready), 32'd1);
    idle(2);

    // Single word and parity corners, bit by bit through the model.
    single_word("w2AAAAA", 22'h2AAAAA);
    single_word("w3FFFFF", 22'h3FFFFF);
    single_word("w000001", 22'h000001);
    single_word("w000000", 22'h000000);

    // Back-to-back with backpressure on a third word.
    fd_times.delete();
    cycle(1'b1, 1'b1, 22'h123456);
    idle(20);
    cycle(1'b1, 1'b1, 22'h0ABCDE);
    check("b2b_second_held", 32'(in_ready), 32'd0);
    m_acc_flag = 1'b0;
    n = 0;
    while (!m_acc_flag && n < 3 * FRAME_LEN) begin
      cycle(1'b1, 1'b1, (n < 30) ? 22'h155555 : 22'h2AAAAA);
      n++;
    end
    check("bp_accepted", 32'(m_acc_flag), 32'd1);
    check("bp_value", 32'(m_hold), 32'h2AAAAA);
    idle(2 * FRAME_LEN + 4);
    check("b2b_fd_count", 32'(fd_times.size()), 32'd3);
    if (fd_times.size() >= 2) begin
      check("b2b_fd_gap", 32'(fd_times[1] - fd_times[0]), 32'(FRAME_LEN));
    end else begin
      check("b2b_fd_gap", 32'hFFFF_FFFF, 32'(FRAME_LEN));
    end

    // Reset during data bit 10 with a second word held.
    fd_times.delete();
    cycle(1'b1, 1'b1, 22'h0F0F0F);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 22'h3C3C3C);
    idle(43);
    cycle(1'b0, 1'b0, '0);
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    idle(2 * FRAME_LEN);
    check("midrst_no_fd", 32'(fd_times.size()), 32'd0);

    // Randomized handshake traffic with rare resets.
    for (int i = 0; i < 2500; i++) begin
      d = DATA_W'($urandom);
      cycle(($urandom_range(0, 999) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, d);
    end
    idle(FRAME_LEN * 2 + 4);
    check("final_idle_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
